// File: rtl/poly_mem_loader.sv
// poly_mem_loader
// Drains a stream of coefficient-pair words from a FIFO into a dual-port
// coefficient memory. Each popped word carries two coefficients (lane a in the
// lower slot, lane b in the upper slot) which are written to consecutive
// addresses one cycle after the pop. A job loads poly_num polynomials of
// N_COEF coefficients each, then pulses module_done.
module poly_mem_loader #(
    parameter int COEF_W   = 23,
    parameter int SLOT_W   = 32,
    parameter int N_COEF   = 256,
    parameter int MAX_POLY = 8,
    parameter int Q        = 8380417,
    localparam int ADDR_W  = $clog2(N_COEF) + $clog2(MAX_POLY),
    localparam int PN_W    = $clog2(MAX_POLY) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                module_start,
    input  logic                module_abort,
    input  logic [PN_W-1:0]     poly_num,
    input  logic                Rm_tvalid,
    input  logic [2*SLOT_W-1:0] Rm_tdata,
    output logic                rd_en,
    output logic                coef_ena,
    output logic                coef_wea,
    output logic [ADDR_W-1:0]   coef_addra,
    output logic [COEF_W-1:0]   coef_dina,
    output logic                coef_enb,
    output logic                coef_web,
    output logic [ADDR_W-1:0]   coef_addrb,
    output logic [COEF_W-1:0]   coef_dinb,
    output logic                busy,
    output logic                module_done,
    output logic                range_err
);

    localparam int CNT_W = $clog2(N_COEF);
    localparam int PI_W  = $clog2(MAX_POLY);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_COEF - 2);
    localparam logic [SLOT_W:0]   Q_EXT    = (SLOT_W + 1)'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   coef_cnt;
    logic [PI_W-1:0]    poly_idx;
    logic [PI_W-1:0]    poly_last;
    logic               last_word;
    logic               word_bad;

    // A slot is out of range when its numeric value reaches Q; since Q fits
    // in COEF_W bits this also catches any stray bit above the coefficient.
    function automatic logic slot_bad(input logic [SLOT_W-1:0] slot);
        return ((slot >> COEF_W) != '0) || ({1'b0, slot} >= Q_EXT);
    endfunction

    // Index of the final polynomial: zero requests load one polynomial and
    // oversize requests are clamped to the memory capacity.
    function automatic logic [PI_W-1:0] last_index(input logic [PN_W-1:0] n);
        if (n == '0) begin
            return '0;
        end else if (n >= PN_W'(MAX_POLY)) begin
            return PI_W'(MAX_POLY - 1);
        end else begin
            return PI_W'(n - PN_W'(1));
        end
    endfunction

    // Pop only while loading; abort kills the pop in the same cycle.
    assign rd_en     = (state == S_LOAD) && Rm_tvalid && !module_abort;
    assign last_word = (poly_idx == poly_last) && (coef_cnt == CNT_LAST);
    assign word_bad  = slot_bad(Rm_tdata[SLOT_W-1:0]) ||
                       slot_bad(Rm_tdata[2*SLOT_W-1:SLOT_W]);
    assign busy      = (state != S_IDLE);

    // Job sequencing, coefficient counters and the registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            coef_cnt    <= '0;
            poly_idx    <= '0;
            poly_last   <= '0;
            coef_ena    <= 1'b0;
            coef_wea    <= 1'b0;
            coef_addra  <= '0;
            coef_dina   <= '0;
            coef_enb    <= 1'b0;
            coef_web    <= 1'b0;
            coef_addrb  <= '0;
            coef_dinb   <= '0;
            module_done <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            coef_ena    <= 1'b0;
            coef_wea    <= 1'b0;
            coef_enb    <= 1'b0;
            coef_web    <= 1'b0;
            module_done <= 1'b0;

            if (rd_en) begin
                coef_ena   <= 1'b1;
                coef_wea   <= 1'b1;
                coef_enb   <= 1'b1;
                coef_web   <= 1'b1;
                coef_addra <= {poly_idx, coef_cnt};
                coef_addrb <= {poly_idx, coef_cnt} + ADDR_W'(1);
                coef_dina  <= Rm_tdata[COEF_W-1:0];
                coef_dinb  <= Rm_tdata[SLOT_W+COEF_W-1:SLOT_W];
                if (word_bad) begin
                    range_err <= 1'b1;
                end
                if (coef_cnt == CNT_LAST) begin
                    coef_cnt <= '0;
                    poly_idx <= poly_idx + PI_W'(1);
                end else begin
                    coef_cnt <= coef_cnt + CNT_W'(2);
                end
            end

            case (state)
                S_IDLE: begin
                    if (module_start && !module_abort) begin
                        state     <= S_LOAD;
                        poly_last <= last_index(poly_num);
                        coef_cnt  <= '0;
                        poly_idx  <= '0;
                        range_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (module_abort) begin
                        state <= S_IDLE;
                    end else if (rd_en && last_word) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (module_abort) begin
                        state <= S_IDLE;
                    end else begin
                        state       <= S_DONE;
                        module_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/poly_mem_loader.md
POLY_MEM_LOADER -- requirements
Module: poly_mem_loader

Interface
REQ-001 SHALL have parameter COEF_W, default 23, coefficient width written to memory.
REQ-002 SHALL have parameter SLOT_W, default 32, stream slot width per coefficient; lane a = bits [COEF_W-1:0], lane b = bits [SLOT_W+COEF_W-1:SLOT_W].
REQ-003 SHALL have parameter N_COEF, default 256, coefficients per polynomial (power of 2, >=4).
REQ-004 SHALL have parameter MAX_POLY, default 8, maximum polynomials per job (power of 2).
REQ-005 SHALL have parameter Q, default 8380417, modulus for the range check.
REQ-006 SHALL derive ADDR_W = log2(N_COEF)+log2(MAX_POLY) and PN_W = log2(MAX_POLY)+1.
REQ-007 SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-008 SHALL have ports: module_start in 1 job start pulse; module_abort in 1 sync abort; poly_num in PN_W polynomials in job, sampled at start.
REQ-009 SHALL have ports: Rm_tvalid in 1 FIFO word valid; Rm_tdata in 2*SLOT_W FIFO word; rd_en out 1 FIFO pop.
REQ-010 SHALL have ports: coef_ena/coef_wea out 1, coef_addra out ADDR_W, coef_dina out COEF_W; coef_enb/coef_web out 1, coef_addrb out ADDR_W, coef_dinb out COEF_W.
REQ-011 SHALL have ports: busy out 1; module_done out 1 pulse; range_err out 1 sticky error.
REQ-012 One clock domain clk; reset rst_n asynchronous, active-low.

Function
REQ-013 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-014 IDLE->LOAD on module_start; latch poly_num (0 treated as 1, >MAX_POLY clamped to MAX_POLY); clear coef counter, poly index, range_err.
REQ-015 module_start while busy SHALL be ignored.
REQ-016 rd_en = (state==LOAD) & Rm_tvalid, combinational; no pop in any other state.
REQ-017 Each rd_en cycle SHALL consume one word: coef counter += 2; at counter N_COEF-2 it wraps to 0 and poly index += 1.
REQ-018 Write latency 1 cycle: cycle after pop, coef_ena=coef_enb=1, addra = poly_idx*N_COEF + counter, addrb = addra+1, data from registered word lanes.
REQ-019 coef_wea/coef_web SHALL equal coef_ena/coef_enb; all enables 0 when no write.
REQ-020 Tvalid gaps SHALL stall counter and writes without loss or duplication.
REQ-021 Pop of last word (poly_idx==poly_num-1, counter==N_COEF-2) SHALL transition LOAD->FLUSH.
REQ-022 FLUSH (1 cycle, last write issued) -> DONE; DONE asserts module_done for exactly 1 cycle -> IDLE.
REQ-023 busy = 1 in LOAD, FLUSH, DONE; 0 in IDLE.
REQ-024 range_err SHALL set if any written lane has slot bits above COEF_W nonzero or value >= Q; sticky until next accepted start; writes still performed unchanged.
REQ-025 module_abort in LOAD/FLUSH SHALL return to IDLE next cycle, no module_done, rd_en deasserted same cycle; a write already in flight completes; abort has priority over start and over last-word detection.
REQ-026 Total words consumed per job = poly_num*N_COEF/2 exactly.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counters 0, rd_en 0, all coef enables 0, addresses/data 0, busy 0, module_done 0, range_err 0.
REQ-028 Reset mid-job SHALL discard the job; no module_done after release; new job requires module_start.

Verification
REQ-029 poly_num=1, Rm_tvalid constant 1, words {k+1 in upper slot, k in lower} -> 128 pops, addr 0..255 written in order, module_done 2 cycles after last pop, range_err 0.
REQ-030 poly_num=3, random tvalid gaps -> 384 pops, addresses 0..767 each written once, no write while tvalid low before stall.
REQ-031 word with lower slot 0x007FE001 (=Q) at position 5 -> range_err=1 at done, memory holds 0x7FE001 at address 10.
REQ-032 module_abort at word 40 of poly_num=2 -> rd_en 0 same cycle, busy 0 next cycle, no module_done; new start restarts at address 0.
REQ-033 rst_n low at word 100 -> all outputs 0 immediately; after release, start with poly_num=0 -> loads one polynomial (128 pops).
REQ-034 module_start pulses during LOAD -> ignored, pop count and done timing unchanged.
